// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: 1080p60 CEA defaults, derived totals, and the
// generator state encoding.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;
    localparam int DEF_CNT_W    = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int h_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    function automatic int v_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

endpackage

// File: rtl/timing_axis_cnt.sv
// One timing axis: wrapping position counter with enable. Region flags and the
// active-relative position describe the count that will be held next cycle.
module timing_axis_cnt #(
    parameter int W      = 12,
    parameter int SYNC   = 44,
    parameter int BP     = 148,
    parameter int ACTIVE = 1920,
    parameter int TOTAL  = 2200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic         wrap,
    output logic         next_sync,
    output logic         next_active,
    output logic [W-1:0] next_pos
);

    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_START = W'(SYNC + BP);
    // One extra bit so an active region ending exactly at 2^W still compares correctly.
    localparam logic [W:0]   ACT_END   = (W+1)'(SYNC + BP + ACTIVE);
    localparam logic [W:0]   SYNC_END  = (W+1)'(SYNC);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign next_sync   = {1'b0, cnt_d} < SYNC_END;
    assign next_active = (cnt_d >= ACT_START) && ({1'b0, cnt_d} < ACT_END);
    assign next_pos    = cnt_d - ACT_START;

endmodule

// File: rtl/frame_timing_gen.sv
// Single-shot frame timing generator with a one-deep retrigger queue.
// Define FRAME_TIMING_FRAME_CNT_EN to add the 16-bit completed-frame counter port.
module frame_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_trig,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             h_sync_out,
    output logic             v_sync_out,
    output logic             de_out,
    output logic [CNT_W-1:0] active_x,
    output logic [CNT_W-1:0] active_y
`ifdef FRAME_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    state_t state_q, state_d;
    logic   pending_q, pending_d;
    logic   done_q, done_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;
    logic   de_q, de_d;
    logic [CNT_W-1:0] ax_q, ax_d;
    logic [CNT_W-1:0] ay_q, ay_d;

    logic             run;
    logic             run_d;
    logic             h_wrap, v_wrap;
    logic             h_nsync, h_nact, v_nsync, v_nact;
    logic [CNT_W-1:0] h_npos, v_npos;

    assign run = (state_q == RUN);

    timing_axis_cnt #(
        .W      (CNT_W),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .TOTAL  (H_TOTAL)
    ) u_h_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (run),
        .wrap        (h_wrap),
        .next_sync   (h_nsync),
        .next_active (h_nact),
        .next_pos    (h_npos)
    );

    // Vertical steps once per line; its wrap therefore marks the last clock of the frame.
    timing_axis_cnt #(
        .W      (CNT_W),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .TOTAL  (V_TOTAL)
    ) u_v_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (h_wrap),
        .wrap        (v_wrap),
        .next_sync   (v_nsync),
        .next_active (v_nact),
        .next_pos    (v_npos)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_trig) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (v_wrap) begin
                    // A trigger landing on the final clock is honoured like a queued one.
                    done_d    = 1'b1;
                    pending_d = 1'b0;
                    if (!(pending_q || frame_trig)) begin
                        state_d = IDLE;
                    end
                end else if (frame_trig) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        run_d = (state_d == RUN);
        hs_d  = run_d && h_nsync;
        vs_d  = run_d && v_nsync;
        de_d  = run_d && h_nact && v_nact;
        ax_d  = de_d ? h_npos : '0;
        ay_d  = de_d ? v_npos : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            ax_q      <= '0;
            ay_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
        end
    end

    assign frame_busy = run;
    assign frame_done = done_q;
    assign h_sync_out = hs_q;
    assign v_sync_out = vs_q;
    assign de_out     = de_q;
    assign active_x   = ax_q;
    assign active_y   = ay_q;

`ifdef FRAME_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (done_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_frame_timing_gen.sv
// Directed bench for frame_timing_gen using a small 14x7 timing (98 clocks per frame).
module tb_frame_timing_gen;

    logic        clk;
    logic        rst_n;
    logic        frame_trig;
    logic        frame_busy;
    logic        frame_done;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        de_out;
    logic [11:0] active_x;
    logic [11:0] active_y;
`ifdef FRAME_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int errors = 0;
    int checks = 0;

    frame_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (2),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .CNT_W    (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_trig (frame_trig),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .de_out     (de_out),
`ifdef FRAME_TIMING_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .active_x   (active_x),
        .active_y   (active_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_trig = 1'b0;
        repeat (3) step();
        checks++;
        if ({frame_busy, frame_done, h_sync_out, v_sync_out, de_out, active_x, active_y} !== '0)
            $display("FAIL reset_hold: busy=%b done=%b hs=%b vs=%b de=%b x=%0d y=%0d, required all 0",
                     frame_busy, frame_done, h_sync_out, v_sync_out, de_out, active_x, active_y);
        rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            checks++;
            if ({frame_busy, frame_done, h_sync_out, v_sync_out, de_out, active_x, active_y} !== '0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: busy=%b done=%b hs=%b vs=%b de=%b x=%0d y=%0d, required all 0",
                         k, frame_busy, frame_done, h_sync_out, v_sync_out, de_out, active_x, active_y);
            end
        end
`ifdef FRAME_TIMING_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_reset: got %0d, required 0", frame_cnt);
        end
`endif
        $display("test_reset: done, errors so far %0d", errors);
    endtask

    task automatic test_single_frame();
        int   p, h, v;
        int   de_cnt, hs_rise, hs_high;
        logic hs_prev;
        logic e_busy, e_done, e_hs, e_vs, e_de;
        logic [11:0] e_ax, e_ay;
        de_cnt = 0; hs_rise = 0; hs_high = 0; hs_prev = 1'b0;
        frame_trig = 1'b1;
        step();
        frame_trig = 1'b0;
        for (int k = 1; k <= 102; k++) begin
            p = k - 1; h = p % 14; v = p / 14;
            e_busy = (k <= 98);
            e_done = (k == 99);
            e_hs   = e_busy && (h < 2);
            e_vs   = e_busy && (v < 1);
            e_de   = e_busy && (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
            e_ax   = e_de ? 12'(h - 4) : 12'd0;
            e_ay   = e_de ? 12'(v - 2) : 12'd0;
            checks++;
            if ({frame_busy, frame_done, h_sync_out, v_sync_out, de_out} !== {e_busy, e_done, e_hs, e_vs, e_de}) begin
                errors++;
                $display("FAIL single_ctrl t+%0d: busy/done/hs/vs/de=%b%b%b%b%b, required %b%b%b%b%b",
                         k, frame_busy, frame_done, h_sync_out, v_sync_out, de_out,
                         e_busy, e_done, e_hs, e_vs, e_de);
            end
            checks++;
            if (active_x !== e_ax || active_y !== e_ay) begin
                errors++;
                $display("FAIL single_coord t+%0d: x=%0d y=%0d, required x=%0d y=%0d",
                         k, active_x, active_y, e_ax, e_ay);
            end
            if (de_out === 1'b1) de_cnt++;
            if (h_sync_out === 1'b1) hs_high++;
            if (h_sync_out === 1'b1 && hs_prev === 1'b0) hs_rise++;
            hs_prev = h_sync_out;
            step();
        end
        checks++;
        if (de_cnt != 32) begin
            errors++;
            $display("FAIL de_count: got %0d clocks, required 32", de_cnt);
        end
        checks++;
        if (hs_rise != 7 || hs_high != 14) begin
            errors++;
            $display("FAIL hsync_pulses: got %0d pulses %0d clocks, required 7 pulses 14 clocks", hs_rise, hs_high);
        end
        $display("test_single_frame: done, errors so far %0d", errors);
    endtask

    task automatic test_back_to_back();
        int   p, h, v;
        logic e_busy, e_done, e_hs, e_vs, e_de;
        logic [11:0] e_ax, e_ay;
        frame_trig = 1'b1;
        step();
        for (int k = 1; k <= 200; k++) begin
            frame_trig = 1'b0;
            p = (k - 1) % 98; h = p % 14; v = p / 14;
            e_busy = (k <= 196);
            e_done = (k == 99) || (k == 197);
            e_hs   = e_busy && (h < 2);
            e_vs   = e_busy && (v < 1);
            e_de   = e_busy && (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
            e_ax   = e_de ? 12'(h - 4) : 12'd0;
            e_ay   = e_de ? 12'(v - 2) : 12'd0;
            checks++;
            if ({frame_busy, frame_done, h_sync_out, v_sync_out, de_out} !== {e_busy, e_done, e_hs, e_vs, e_de}
                || active_x !== e_ax || active_y !== e_ay) begin
                errors++;
                $display("FAIL b2b t+%0d: busy/done/hs/vs/de=%b%b%b%b%b x=%0d y=%0d, required %b%b%b%b%b x=%0d y=%0d",
                         k, frame_busy, frame_done, h_sync_out, v_sync_out, de_out, active_x, active_y,
                         e_busy, e_done, e_hs, e_vs, e_de, e_ax, e_ay);
            end
            if (k == 50 || k == 60) frame_trig = 1'b1;
            step();
        end
        frame_trig = 1'b0;
        $display("test_back_to_back: done, errors so far %0d", errors);
    endtask

    task automatic test_end_trigger();
        int   p, h, v;
        logic e_busy, e_done, e_hs, e_vs;
        frame_trig = 1'b1;
        step();
        for (int k = 1; k <= 200; k++) begin
            frame_trig = 1'b0;
            p = (k - 1) % 98; h = p % 14; v = p / 14;
            e_busy = (k <= 196);
            e_done = (k == 99) || (k == 197);
            e_hs   = e_busy && (h < 2);
            e_vs   = e_busy && (v < 1);
            checks++;
            if ({frame_busy, frame_done, h_sync_out, v_sync_out} !== {e_busy, e_done, e_hs, e_vs}) begin
                errors++;
                $display("FAIL end_trig t+%0d: busy/done/hs/vs=%b%b%b%b, required %b%b%b%b",
                         k, frame_busy, frame_done, h_sync_out, v_sync_out, e_busy, e_done, e_hs, e_vs);
            end
            // Drive during the last position clock so it is sampled at the frame-end edge.
            if (k == 98) frame_trig = 1'b1;
            step();
        end
        frame_trig = 1'b0;
        $display("test_end_trigger: done, errors so far %0d", errors);
    endtask

    task automatic test_reset_mid();
        frame_trig = 1'b1;
        step();
        frame_trig = 1'b0;
        repeat (39) step();
        checks++;
        if (de_out !== 1'b1 || active_x !== 12'd7 || active_y !== 12'd0) begin
            errors++;
            $display("FAIL pre_reset_pos t+40: de=%b x=%0d y=%0d, required de=1 x=7 y=0", de_out, active_x, active_y);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({frame_busy, frame_done, h_sync_out, v_sync_out, de_out, active_x, active_y} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b hs=%b vs=%b de=%b x=%0d y=%0d, required all 0",
                     frame_busy, frame_done, h_sync_out, v_sync_out, de_out, active_x, active_y);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (frame_done !== 1'b0 || frame_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done cycle %0d: done=%b busy=%b, required 0 0", k, frame_done, frame_busy);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (frame_busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: busy=%b done=%b, required 0 0", k, frame_busy, frame_done);
            end
        end
`ifdef FRAME_TIMING_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_after_reset: got %0d, required 0", frame_cnt);
        end
`endif
        for (int f = 0; f < 3; f++) begin
            frame_trig = 1'b1;
            step();
            frame_trig = 1'b0;
            checks++;
            if (frame_busy !== 1'b1 || h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin
                errors++;
                $display("FAIL clean_start frame %0d: busy=%b hs=%b vs=%b, required 1 1 1", f, frame_busy, h_sync_out, v_sync_out);
            end
            repeat (98) step();
            checks++;
            if (frame_done !== 1'b1 || frame_busy !== 1'b0) begin
                errors++;
                $display("FAIL clean_end frame %0d: done=%b busy=%b, required 1 0", f, frame_done, frame_busy);
            end
            step();
        end
`ifdef FRAME_TIMING_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL frame_cnt_three: got %0d, required 3", frame_cnt);
        end
`endif
        $display("test_reset_mid: done, errors so far %0d", errors);
    endtask

    initial begin
        rst_n = 1'b0;
        frame_trig = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        repeat (3) step();
        test_end_trigger();
        repeat (3) step();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
